id_pipe: RTL and testbench
==========================

// Module: id_pipe
// PURPOSE
//  Registered, parametrised MIPS decode stage with an ID/EX pipeline register between IF and EX.
//  Decodes R-type ALU/shift ops, LUI and (optionally) I-type ALU ops onto the existing 14-bit one-hot aluop.
//  Resolves operands with EX/MEM forwarding and applies a valid/ready handshake on both sides.
// PARAMETERS
//  DATA_W    32  operand/result width; >=32; immediates extend to DATA_W
//  REG_AW    5   register address width
//  EN_ITYPE  1   1: decode ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI; 0: these flag illegal
//  EN_FWD    1   1: EX/MEM forwarding active; 0: regfile data only
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous reset, active-high
//  inst_i       in   32      instruction from IF
//  in_valid_i   in   1       inst_i valid
//  in_ready_o   out  1       stage can accept inst_i this cycle
//  reg1_addr_o  out  REG_AW  regfile read addr 1 = inst_i[25:21] (comb.)
//  reg2_addr_o  out  REG_AW  regfile read addr 2 = inst_i[20:16] (comb.)
//  reg1_read_o  out  1       port 1 used (comb.)
//  reg2_read_o  out  1       port 2 used (comb.)
//  reg1_data_i  in   DATA_W  regfile data 1
//  reg2_data_i  in   DATA_W  regfile data 2
//  ex_wreg_i    in   1       EX-stage result will be written
//  ex_wd_i      in   REG_AW  EX-stage destination
//  ex_wdata_i   in   DATA_W  EX-stage result
//  mem_wreg_i   in   1       MEM-stage write enable
//  mem_wd_i     in   REG_AW  MEM-stage destination
//  mem_wdata_i  in   DATA_W  MEM-stage data
//  flush_i      in   1       discard held and incoming instruction
//  out_valid_o  out  1       ID/EX register holds an instruction
//  out_ready_i  in   1       EX accepts this cycle
//  aluop_o      out  14      one-hot {add,addu,sub,subu,slt,sltu,and,or,xor,nor,sll,srl,sra,lui}
//  reg1_o       out  DATA_W  operand 1
//  reg2_o       out  DATA_W  operand 2
//  wd_o         out  REG_AW  destination register
//  wreg_o       out  1       write enable
//  illegal_o    out  1       instruction not recognised
// BEHAVIOUR
//  - Reset: out_valid_o, aluop_o, reg1_o, reg2_o, wd_o, wreg_o, illegal_o all 0. Comb. outputs are 0 while rst=1.
//  - in_ready_o = !out_valid_o || out_ready_i. Accept = in_valid_i && in_ready_o. Accepted instr. appears on registered outputs next cycle; latency 1.
//  - Stall (out_valid_o && !out_ready_i): all registered outputs held bit-stable.
//  - Empty after handoff (out_ready_i && !accept): out_valid_o -> 0; data fields don't care.
//  - Decode, op=inst[31:26], fn=inst[5:0]:
//    op=0 and sa=0: ADD/ADDU/SUB/SUBU/SLT/SLTU/AND/OR/XOR/NOR by fn; rs/rt read; dest rd.
//    op=0 and rs=0: SLL(0)/SRL(2)/SRA(3); reg1 = zext(sa); reg2 = rt; dest rd.
//    op=0x0F with rs=0: LUI; reg2 = {imm16,0} zero-filled to DATA_W; reg1 = 0; dest rt.
//    I-type (EN_ITYPE): ADDI->add, ADDIU->addu, SLTI->slt, SLTIU->sltu use sext(imm16); ANDI->and, ORI->or, XORI->xor use zext(imm16).
//    For I-type: reg1 = rs; reg2 = imm; dest rt.
//  - Illegal: any other encoding. aluop=0, wreg=0, illegal_o=1; still passes handshake.
//  - wreg_o = legal && dest!=0.
//  - Forwarding (EN_FWD=1), evaluated in the accept cycle, per read port, addr!=0 only:
//    EX match beats MEM match beats regfile.
//  - flush_i: out_valid_o -> 0 next cycle; in_ready_o forced 1; a same-cycle accept is discarded.
//    flush_i wins over a concurrent accept or stall.
//  - rst mid-stall clears everything identically to power-on reset; rst dominates flush_i.
// TESTING
//  1. ADD $3,$1,$2, rf 5/7, out_ready=1 -> next cycle: aluop=14'h2000, reg1=5, reg2=7, wd=3, wreg=1.
//  2. ADDI $4,$1,-1 (imm 0xFFFF) -> aluop=add, reg2=32'hFFFF_FFFF; same with ORI -> reg2=32'h0000_FFFF.
//  3. Forwarding: rs=$1 with ex_wd=1 (0xAA) and mem_wd=1 (0xBB) -> reg1=0xAA; rs=$0 with ex_wd=0 -> reg1 = rf value.
//  4. Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; release -> next instr. loads 1 cycle later.
//  5. flush_i with in_valid=1 and stalled output -> out_valid=0 next cycle; instruction never emitted.
//  6. Illegal op 0x3F, and EN_ITYPE=0 with ADDI -> illegal_o=1, aluop=0, wreg=0; rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/id_pipe.sv
// id_pipe: MIPS decode stage with EX/MEM forwarding and a valid/ready ID/EX register
module id_pipe #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter bit EN_ITYPE = 1,
  parameter bit EN_FWD   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [13:0]       aluop_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic              illegal_o
);
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sa;
  logic [15:0] imm;
  logic [13:0] fdec, odec, aluop_d;
  logic shift, lui, legal, read1, read2, accept;
  logic [REG_AW-1:0] a1, a2, dest;
  logic [DATA_W-1:0] f1, f2, op1, op2;
  assign {op, rs, rt, rd, sa, fn} = inst_i;
  assign imm = inst_i[15:0];
  always_comb begin
    fdec = '0;
    case (fn)
      6'h00: fdec = 14'h0008;
      6'h02: fdec = 14'h0004;
      6'h03: fdec = 14'h0002;
      6'h20: fdec = 14'h2000;
      6'h21: fdec = 14'h1000;
      6'h22: fdec = 14'h0800;
      6'h23: fdec = 14'h0400;
      6'h24: fdec = 14'h0080;
      6'h25: fdec = 14'h0040;
      6'h26: fdec = 14'h0020;
      6'h27: fdec = 14'h0010;
      6'h2a: fdec = 14'h0200;
      6'h2b: fdec = 14'h0100;
      default: fdec = '0;
    endcase
    odec = '0;
    case (op)
      6'h08: odec = 14'h2000;
      6'h09: odec = 14'h1000;
      6'h0a: odec = 14'h0200;
      6'h0b: odec = 14'h0100;
      6'h0c: odec = 14'h0080;
      6'h0d: odec = 14'h0040;
      6'h0e: odec = 14'h0020;
      default: odec = '0;
    endcase
  end
  assign shift = op == 6'h00 && rs == 5'd0 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
  assign lui = op == 6'h0f && rs == 5'd0;
  assign aluop_d = op == 6'h00 ? (shift || (sa == 5'd0 && fn[5]) ? fdec : '0) :
                   lui ? 14'h0001 : EN_ITYPE ? odec : '0;
  assign legal = |aluop_d;
  assign read1 = legal && !shift && !lui;
  assign read2 = legal && op == 6'h00;
  assign a1 = REG_AW'(rs);
  assign a2 = REG_AW'(rt);
  assign dest = op == 6'h00 ? REG_AW'(rd) : REG_AW'(rt);
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] rf);
    if (!EN_FWD || a == '0) return rf;
    return ex_wreg_i && ex_wd_i == a ? ex_wdata_i : mem_wreg_i && mem_wd_i == a ? mem_wdata_i : rf;
  endfunction
  always_comb begin
    f1 = fwd(a1, reg1_data_i);
    f2 = fwd(a2, reg2_data_i);
    op1 = read1 ? f1 : shift ? DATA_W'(sa) : '0;
    op2 = read2 ? f2 : lui ? DATA_W'({imm, 16'h0}) :
          op[3:2] == 2'b10 ? DATA_W'($signed(imm)) : DATA_W'(imm);
  end
  assign in_ready_o = !rst && (flush_i || !out_valid_o || out_ready_i);
  assign accept = in_valid_i && in_ready_o;
  assign reg1_addr_o = rst ? '0 : a1;
  assign reg2_addr_o = rst ? '0 : a2;
  assign reg1_read_o = !rst && read1;
  assign reg2_read_o = !rst && read2;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid_o <= 1'b0;
      aluop_o <= '0;
      reg1_o <= '0;
      reg2_o <= '0;
      wd_o <= '0;
      wreg_o <= 1'b0;
      illegal_o <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      aluop_o <= aluop_d;
      reg1_o <= op1;
      reg2_o <= op2;
      wd_o <= dest;
      wreg_o <= legal && dest != '0;
      illegal_o <= !legal;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: scoreboard bench for id_pipe, plus an EN_ITYPE=0/EN_FWD=0 instance
module tb_id_pipe;
  typedef struct packed {
    logic [13:0] aluop;
    logic [31:0] r1, r2;
    logic [4:0]  wd;
    logic        wreg, ill, data;
  } exp_t;
  logic clk = 0, rst = 1;
  logic [31:0] inst_i = 0;
  logic in_valid_i = 0, out_ready_i = 1, flush_i = 0;
  logic [31:0] reg1_data_i = 5, reg2_data_i = 7;
  logic ex_wreg_i = 0, mem_wreg_i = 0;
  logic [4:0] ex_wd_i = 0, mem_wd_i = 0;
  logic [31:0] ex_wdata_i = 0, mem_wdata_i = 0;
  logic in_ready_o, reg1_read_o, reg2_read_o, out_valid_o, wreg_o, illegal_o;
  logic [4:0] reg1_addr_o, reg2_addr_o, wd_o;
  logic [13:0] aluop_o;
  logic [31:0] reg1_o, reg2_o;
  logic ni_in_ready, ni_r1r, ni_r2r, ni_ov, ni_wreg, ni_ill;
  logic [4:0] ni_r1a, ni_r2a, ni_wd;
  logic [13:0] ni_aluop;
  logic [31:0] ni_reg1, ni_reg2;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  id_pipe dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .aluop_o(aluop_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .illegal_o(illegal_o)
  );
  id_pipe #(.EN_ITYPE(0), .EN_FWD(0)) dut_ni (
    .clk(clk), .rst(rst), .inst_i(inst_i), .in_valid_i(in_valid_i), .in_ready_o(ni_in_ready),
    .reg1_addr_o(ni_r1a), .reg2_addr_o(ni_r2a), .reg1_read_o(ni_r1r), .reg2_read_o(ni_r2r),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .out_valid_o(ni_ov), .out_ready_i(out_ready_i),
    .aluop_o(ni_aluop), .reg1_o(ni_reg1), .reg2_o(ni_reg2), .wd_o(ni_wd), .wreg_o(ni_wreg), .illegal_o(ni_ill)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk) #1;
  endtask
  task automatic send(input logic [31:0] inst, input exp_t x);
    inst_i = inst;
    in_valid_i = 1;
    #1;
    for (int i = 0; i < 20 && !in_ready_o; i++) @(posedge clk) #1;
    check("accept_ready", in_ready_o, 1);
    sb.push_back(x);
    @(posedge clk) #1;
    in_valid_i = 0;
  endtask
  always @(negedge clk)
    if (!rst && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) check("unexpected_out", out_valid_o, 0);
      else begin
        e = sb.pop_front();
        check("aluop", aluop_o, e.aluop);
        check("wreg", wreg_o, e.wreg);
        check("illegal", illegal_o, e.ill);
        if (e.data) begin
          check("reg1", reg1_o, e.r1);
          check("reg2", reg2_o, e.r2);
          check("wd", wd_o, e.wd);
        end
      end
    end
  initial begin
    inst_i = 32'h00221820;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_o, 0);
    check("rst_read1", reg1_read_o, 0);
    check("rst_addr1", reg1_addr_o, 0);
    check("rst_ni_in_ready", ni_in_ready, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_aluop", aluop_o, 0);
    check("rst_wreg", wreg_o, 0);
    rst = 0;
    inst_i = 32'h2024ffff;
    #1;
    check("addi_addr1", reg1_addr_o, 1);
    check("addi_addr2", reg2_addr_o, 4);
    check("addi_read1", reg1_read_o, 1);
    check("addi_read2", reg2_read_o, 0);
    check("ni_addi_read1", ni_r1r, 0);
    check("ni_addi_read2", ni_r2r, 0);
    check("ni_addr1", ni_r1a, 1);
    check("ni_addr2", ni_r2a, 4);
    inst_i = 32'h00022900;
    #1;
    check("sll_read1", reg1_read_o, 0);
    check("sll_read2", reg2_read_o, 1);
    idle(1);
    send(32'h00221820, '{14'h2000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b1});
    send(32'h2024ffff, '{14'h2000, 32'd5, 32'hffffffff, 5'd4, 1'b1, 1'b0, 1'b1});
    check("ni_addi_illegal", ni_ill, 1);
    check("ni_addi_aluop", ni_aluop, 0);
    check("ni_addi_wreg", ni_wreg, 0);
    check("ni_addi_valid", ni_ov, 1);
    send(32'h3424ffff, '{14'h0040, 32'd5, 32'h0000ffff, 5'd4, 1'b1, 1'b0, 1'b1});
    ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'haa;
    mem_wreg_i = 1; mem_wd_i = 1; mem_wdata_i = 32'hbb;
    send(32'h00221820, '{14'h2000, 32'haa, 32'd7, 5'd3, 1'b1, 1'b0, 1'b1});
    check("ni_nofwd_reg1", ni_reg1, 5);
    check("ni_nofwd_reg2", ni_reg2, 7);
    check("ni_wd", ni_wd, 3);
    ex_wd_i = 3; mem_wd_i = 2;
    send(32'h00221820, '{14'h2000, 32'd5, 32'hbb, 5'd3, 1'b1, 1'b0, 1'b1});
    ex_wd_i = 0; mem_wd_i = 0; reg1_data_i = 9;
    send(32'h00021820, '{14'h2000, 32'd9, 32'd7, 5'd3, 1'b1, 1'b0, 1'b1});
    ex_wreg_i = 0; mem_wreg_i = 0; reg1_data_i = 5;
    send(32'h00022900, '{14'h0008, 32'd4, 32'd7, 5'd5, 1'b1, 1'b0, 1'b1});
    send(32'h000237c3, '{14'h0002, 32'd31, 32'd7, 5'd6, 1'b1, 1'b0, 1'b1});
    send(32'h3c071234, '{14'h0001, 32'd0, 32'h12340000, 5'd7, 1'b1, 1'b0, 1'b1});
    send(32'h00220020, '{14'h2000, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0, 1'b1});
    send(32'hfc000000, '{14'h0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0});
    send(32'h3c271234, '{14'h0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0});
    idle(2);
    out_ready_i = 0;
    send(32'h00221822, '{14'h0800, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b1});
    inst_i = 32'h00224026;
    in_valid_i = 1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", in_ready_o, 0);
      check("stall_valid", out_valid_o, 1);
      check("stall_aluop", aluop_o, 14'h0800);
      check("stall_wd", wd_o, 3);
    end
    @(posedge clk) #1;
    out_ready_i = 1;
    send(32'h00224026, '{14'h0020, 32'd5, 32'd7, 5'd8, 1'b1, 1'b0, 1'b1});
    idle(2);
    out_ready_i = 0;
    send(32'h00224827, '{14'h0010, 32'd5, 32'd7, 5'd9, 1'b1, 1'b0, 1'b1});
    inst_i = 32'h00225024;
    in_valid_i = 1;
    flush_i = 1;
    #1;
    check("flush_in_ready", in_ready_o, 1);
    @(posedge clk) #1;
    flush_i = 0;
    in_valid_i = 0;
    check("flush_valid", out_valid_o, 0);
    void'(sb.pop_back());
    out_ready_i = 1;
    idle(3);
    out_ready_i = 0;
    send(32'h0022582b, '{14'h0100, 32'd5, 32'd7, 5'd11, 1'b1, 1'b0, 1'b1});
    idle(1);
    rst = 1;
    flush_i = 1;
    in_valid_i = 1;
    #1;
    check("midrst_in_ready", in_ready_o, 0);
    check("midrst_read2", reg2_read_o, 0);
    check("midrst_addr2", reg2_addr_o, 0);
    @(posedge clk) #1;
    rst = 0;
    flush_i = 0;
    in_valid_i = 0;
    check("midrst_valid", out_valid_o, 0);
    check("midrst_aluop", aluop_o, 0);
    check("midrst_reg1", reg1_o, 0);
    check("midrst_reg2", reg2_o, 0);
    check("midrst_wd", wd_o, 0);
    check("midrst_wreg", wreg_o, 0);
    check("midrst_illegal", illegal_o, 0);
    void'(sb.pop_back());
    out_ready_i = 1;
    send(32'h00226025, '{14'h0040, 32'd5, 32'd7, 5'd12, 1'b1, 1'b0, 1'b1});
    idle(3);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
